// File: rtl/sat_accu_mc.sv
// Multi-channel saturating accumulator: tagged samples update one of NUM_CH
// accumulators with optional leak, symmetric clamp and sticky saturation flags.

module sat_accu_ch #(
    parameter int SIZE = 26
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [SIZE-1:0] wr_data,
    input  logic            sat_set,
    input  logic            sat_clr,
    output logic [SIZE-1:0] acc,
    output logic            sat_flag
);
    logic [SIZE-1:0] acc_q, acc_d;
    logic            flag_q, flag_d;

    always_comb begin
        acc_d  = acc_q;
        flag_d = flag_q;
        if (wr_en)   acc_d  = wr_data;
        // A new saturation on this channel outranks a global clear in the same cycle.
        if (sat_clr) flag_d = 1'b0;
        if (sat_set) flag_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= '0;
            flag_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            flag_q <= flag_d;
        end
    end

    assign acc      = acc_q;
    assign sat_flag = flag_q;
endmodule

module sat_accu_mc #(
    parameter int IN_WIDTH   = 15,
    parameter int SIZE       = 26,
    parameter int NUM_CH     = 4,
    parameter int CH_W       = 2,
    parameter int LIMIT      = (2 ** (SIZE - 1)) - 1,
    parameter int LEAK_SHIFT = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [CH_W-1:0]     in_ch,
    input  logic [IN_WIDTH-1:0] in_data,
    input  logic                in_clr,
    input  logic                sat_clr,
    output logic                out_valid,
    output logic [CH_W-1:0]     out_ch,
    output logic [SIZE-1:0]     out_accu,
    output logic                out_sat,
    output logic [NUM_CH-1:0]   sat_flags
);
    localparam int W = SIZE + 2;
    localparam logic [CH_W:0]         NUM_CH_L = (CH_W + 1)'(NUM_CH);
    localparam logic signed [W-1:0]   LIM_P    = W'(LIMIT);
    localparam logic signed [W-1:0]   LIM_N    = -LIM_P;

    logic [NUM_CH-1:0][SIZE-1:0] acc_all;
    logic                        accept;
    logic [CH_W-1:0]             ch_idx;
    logic [SIZE-1:0]             acc_sel;
    logic signed [W-1:0]         acc_ext, din_ext, leak, sum;
    logic [SIZE-1:0]             res;
    logic                        sat;

    assign accept  = in_valid && ({1'b0, in_ch} < NUM_CH_L);
    // Out-of-range channels never reach the array index.
    assign ch_idx  = accept ? in_ch : '0;
    assign acc_sel = acc_all[ch_idx];
    assign acc_ext = {{2{acc_sel[SIZE-1]}}, acc_sel};
    assign din_ext = {{(W - IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};

    if (LEAK_SHIFT > 0) begin : g_leak
        assign leak = acc_ext >>> LEAK_SHIFT;
    end else begin : g_noleak
        assign leak = '0;
    end

    always_comb begin
        sum = in_clr ? din_ext : (acc_ext - leak + din_ext);
        res = sum[SIZE-1:0];
        sat = 1'b0;
        if (sum > LIM_P) begin
            res = LIM_P[SIZE-1:0];
            sat = 1'b1;
        end else if (sum < LIM_N) begin
            res = LIM_N[SIZE-1:0];
            sat = 1'b1;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic wr_en;
        assign wr_en = accept && (in_ch == CH_W'(c));
        sat_accu_ch #(.SIZE(SIZE)) u_ch (
            .clk      (clk),
            .rst      (rst),
            .wr_en    (wr_en),
            .wr_data  (res),
            .sat_set  (wr_en && sat),
            .sat_clr  (sat_clr),
            .acc      (acc_all[c]),
            .sat_flag (sat_flags[c])
        );
    end

    logic            out_valid_q, out_valid_d;
    logic [CH_W-1:0] out_ch_q, out_ch_d;
    logic [SIZE-1:0] out_accu_q, out_accu_d;
    logic            out_sat_q, out_sat_d;

    always_comb begin
        out_valid_d = accept;
        out_ch_d    = out_ch_q;
        out_accu_d  = out_accu_q;
        out_sat_d   = out_sat_q;
        if (accept) begin
            out_ch_d   = in_ch;
            out_accu_d = res;
            out_sat_d  = sat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_accu_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            out_accu_q  <= out_accu_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_accu  = out_accu_q;
    assign out_sat   = out_sat_q;
endmodule

// File: tb/tb_sat_accu_mc.sv
// Bench for sat_accu_mc: three configurations driven in lockstep (plain, leaky,
// three-channel) and compared each cycle against an integer reference model.

module tb_sat_accu_mc;
    localparam int IW  = 6;
    localparam int SZ  = 8;
    localparam int LIM = 100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, in_valid, in_clr, sat_clr;
    logic [1:0]    in_ch;
    logic [IW-1:0] in_data;

    logic          d0_ov, d1_ov, d2_ov;
    logic [1:0]    d0_och, d1_och, d2_och;
    logic [SZ-1:0] d0_acc, d1_acc, d2_acc;
    logic          d0_sat, d1_sat, d2_sat;
    logic [3:0]    d0_flg, d1_flg;
    logic [2:0]    d2_flg;

    sat_accu_mc #(.IN_WIDTH(IW), .SIZE(SZ), .NUM_CH(4), .CH_W(2), .LIMIT(LIM), .LEAK_SHIFT(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ch(in_ch), .in_data(in_data),
        .in_clr(in_clr), .sat_clr(sat_clr), .out_valid(d0_ov), .out_ch(d0_och),
        .out_accu(d0_acc), .out_sat(d0_sat), .sat_flags(d0_flg));

    sat_accu_mc #(.IN_WIDTH(IW), .SIZE(SZ), .NUM_CH(4), .CH_W(2), .LIMIT(LIM), .LEAK_SHIFT(2)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ch(in_ch), .in_data(in_data),
        .in_clr(in_clr), .sat_clr(sat_clr), .out_valid(d1_ov), .out_ch(d1_och),
        .out_accu(d1_acc), .out_sat(d1_sat), .sat_flags(d1_flg));

    sat_accu_mc #(.IN_WIDTH(IW), .SIZE(SZ), .NUM_CH(3), .CH_W(2), .LIMIT(LIM), .LEAK_SHIFT(0)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ch(in_ch), .in_data(in_data),
        .in_clr(in_clr), .sat_clr(sat_clr), .out_valid(d2_ov), .out_ch(d2_och),
        .out_accu(d2_acc), .out_sat(d2_sat), .sat_flags(d2_flg));

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state per configuration: accumulator values, flags, held outputs.
    int m_acc  [3][4];
    int m_flag [3][4];
    int m_ov [3], m_och [3], m_oacc [3], m_osat [3];
    int m_nch [3] = '{4, 4, 3};
    int m_ls  [3] = '{0, 2, 0};

    function automatic int floor_div_pow2(int a, int k);
        int p = 1 << k;
        if (a >= 0) return a / p;
        return -((-a + p - 1) / p);
    endfunction

    task automatic model(int r, int v, int ch, int data, int clr, int sclr);
        for (int d = 0; d < 3; d++) begin
            if (r != 0) begin
                for (int c = 0; c < 4; c++) begin
                    m_acc[d][c]  = 0;
                    m_flag[d][c] = 0;
                end
                m_ov[d] = 0; m_och[d] = 0; m_oacc[d] = 0; m_osat[d] = 0;
            end else begin
                int upd = (v != 0 && ch < m_nch[d]) ? 1 : 0;
                if (sclr != 0)
                    for (int c = 0; c < 4; c++) m_flag[d][c] = 0;
                if (upd != 0) begin
                    int cur  = m_acc[d][ch];
                    int leak = (m_ls[d] > 0) ? floor_div_pow2(cur, m_ls[d]) : 0;
                    int nxt  = (clr != 0) ? data : cur - leak + data;
                    int s    = 0;
                    if (nxt > LIM)       begin nxt = LIM;  s = 1; end
                    else if (nxt < -LIM) begin nxt = -LIM; s = 1; end
                    m_acc[d][ch] = nxt;
                    if (s != 0) m_flag[d][ch] = 1;
                    m_och[d] = ch; m_oacc[d] = nxt; m_osat[d] = s;
                end
                m_ov[d] = upd;
            end
        end
    endtask

    task automatic chk(string tag, int obs, int exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_dut(string nm, int d, logic ov, logic [1:0] och, logic [SZ-1:0] oacc,
                           logic osat, logic [3:0] flg);
        int ef = 0;
        for (int c = 0; c < 4; c++) ef += m_flag[d][c] << c;
        chk({nm, "_out_valid"}, int'(ov), m_ov[d]);
        chk({nm, "_out_ch"},    int'(och), m_och[d]);
        chk({nm, "_out_accu"},  int'($signed(oacc)), m_oacc[d]);
        chk({nm, "_out_sat"},   int'(osat), m_osat[d]);
        chk({nm, "_sat_flags"}, int'(flg), ef);
    endtask

    task automatic step(int r, int v, int ch, int data, int clr, int sclr);
        logic [31:0] dv = 32'(data);
        logic [31:0] cv = 32'(ch);
        rst = r[0]; in_valid = v[0]; in_ch = cv[1:0]; in_data = dv[IW-1:0];
        in_clr = clr[0]; sat_clr = sclr[0];
        model(r, v, ch, data, clr, sclr);
        @(posedge clk);
        @(negedge clk);
        chk_dut("d0", 0, d0_ov, d0_och, d0_acc, d0_sat, d0_flg);
        chk_dut("d1", 1, d1_ov, d1_och, d1_acc, d1_sat, d1_flg);
        chk_dut("d2", 2, d2_ov, d2_och, d2_acc, d2_sat, {1'b0, d2_flg});
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_ch = '0; in_data = '0; in_clr = 1'b0; sat_clr = 1'b0;
        @(negedge clk);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("reset_accu", int'(d0_acc), 0);

        // Basic integration on ch0
        step(0, 1, 0, 10, 0, 0);  chk("basic_10", int'($signed(d0_acc)), 10);
        step(0, 1, 0, 20, 0, 0);  chk("basic_30", int'($signed(d0_acc)), 30);
        step(0, 1, 0, -5, 0, 0);  chk("basic_25", int'($signed(d0_acc)), 25);

        // Positive saturation on ch1
        for (int i = 0; i < 4; i++) step(0, 1, 1, 31, 0, 0);
        chk("pos_clamp", int'($signed(d0_acc)), 100);
        chk("pos_sat", int'(d0_sat), 1);
        chk("pos_flags", int'(d0_flg), 2);
        step(0, 1, 1, -31, 0, 0); chk("pos_back_69", int'($signed(d0_acc)), 69);

        // Negative saturation, set beats clear on the updated channel
        for (int i = 0; i < 4; i++) step(0, 1, 2, -32, 0, 0);
        chk("neg_clamp", int'($signed(d0_acc)), -100);
        step(0, 1, 2, -32, 0, 1);
        chk("set_beats_clr", int'(d0_flg), 4);
        step(0, 0, 0, 0, 0, 1);
        chk("sat_clr_all", int'(d0_flg), 0);

        // Interleave and restart
        step(0, 1, 0, 0, 1, 0);
        step(0, 1, 0, 5, 0, 0);   chk("il_ch0_5", int'($signed(d0_acc)), 5);
        step(0, 1, 3, 7, 0, 0);   chk("il_ch3_7", int'($signed(d0_acc)), 7);
        step(0, 1, 0, 5, 0, 0);   chk("il_ch0_10", int'($signed(d0_acc)), 10);
        step(0, 1, 0, 3, 1, 0);   chk("il_restart", int'($signed(d0_acc)), 3);

        // Leak behaviour on the LEAK_SHIFT=2 instance
        step(0, 1, 0, 0, 1, 0);
        step(0, 1, 0, 16, 0, 0);  chk("leak_16", int'($signed(d1_acc)), 16);
        step(0, 1, 0, 16, 0, 0);  chk("leak_28", int'($signed(d1_acc)), 28);
        step(0, 1, 0, 16, 0, 0);  chk("leak_37", int'($signed(d1_acc)), 37);
        step(0, 1, 0, -20, 1, 0); chk("leak_clr", int'($signed(d1_acc)), -20);
        step(0, 1, 0, 0, 0, 0);   chk("leak_floor", int'($signed(d1_acc)), -15);

        // Reset wins over a simultaneous input; out-of-range channel ignored
        step(1, 1, 1, 9, 0, 0);
        chk("rst_ov", int'(d0_ov), 0);
        step(0, 1, 3, 11, 0, 0);
        chk("oob_ov", int'(d2_ov), 0);
        chk("oob_hold", int'(d2_acc), 0);

        // Randomized traffic, including occasional reset, restart and flag clear
        for (int i = 0; i < 400; i++) begin
            int r    = ($urandom_range(0, 59) == 0) ? 1 : 0;
            int v    = ($urandom_range(0, 3) != 0) ? 1 : 0;
            int ch   = int'($urandom_range(0, 3));
            int data = int'($urandom_range(0, 63)) - 32;
            int clr  = ($urandom_range(0, 9) == 0) ? 1 : 0;
            int sclr = ($urandom_range(0, 14) == 0) ? 1 : 0;
            step(r, v, ch, data, clr, sclr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
